// File: rtl/hit_detector_2d_pkg.sv
// Shared constants and types for the ball collision block and the raster helpers.
// Visible-area constants double as parameter defaults for the instantiating top.
package hit_detector_2d_pkg;

  localparam int H_VISIBLE_AREA = 640;
  localparam int V_VISIBLE_AREA = 480;
  localparam int HIT_COUNT_W    = 8;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } x_dir_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } y_dir_e;

  typedef struct packed {
    logic hit_l;
    logic hit_r;
    logic hit_t;
    logic hit_b;
    logic pad_l;
    logic pad_r;
  } contact_t;

  // Even paddle indices guard the left edge (bounce to +X), odd ones the right edge.
  function automatic logic is_left_paddle(input int idx);
    return (idx % 2) == 0;
  endfunction

endpackage

// File: rtl/raster_position.sv
// Visible-area raster coordinates rebuilt from the blanking strobes, plus the
// registered VBlank-entry detect used as the once-per-frame update strobe.
module raster_position
  import hit_detector_2d_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_AREA,
  parameter int V_VISIBLE = V_VISIBLE_AREA,
  localparam int DX_W = $clog2(H_VISIBLE),
  localparam int DY_W = $clog2(V_VISIBLE)
) (
  input  logic            i_Clk,
  input  logic            i_Reset,
  input  logic            i_HBlank,
  input  logic            i_VBlank,
  output logic [DX_W-1:0] dx,
  output logic [DY_W-1:0] dy,
  output logic            o_FrameEnd
);

  localparam logic [DX_W-1:0] DX_MAX = DX_W'(H_VISIBLE - 1);
  localparam logic [DY_W-1:0] DY_MAX = DY_W'(V_VISIBLE - 1);

  logic hblank_q;
  logic vblank_q;

  // Previous-blank registers reset high so leaving reset inside blanking is not an edge.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      dx       <= '0;
      dy       <= '0;
      hblank_q <= 1'b1;
      vblank_q <= 1'b1;
    end else begin
      hblank_q <= i_HBlank;
      vblank_q <= i_VBlank;
      if (i_HBlank) begin
        dx <= '0;
      end else if (dx != DX_MAX) begin
        dx <= dx + 1'b1;
      end
      if (i_VBlank) begin
        dy <= '0;
      end else if (i_HBlank && !hblank_q && (dy != DY_MAX)) begin
        dy <= dy + 1'b1;
      end
    end
  end

  assign o_FrameEnd = i_VBlank & ~vblank_q;

endmodule

// File: rtl/hit_detector_2d.sv
// Ball collision detector: accumulates edge/paddle contacts over the visible frame
// and flips direction once at VBlank entry. Define HIT_DETECTOR_COUNT_EN for o_HitCount.
module hit_detector_2d
  import hit_detector_2d_pkg::*;
#(
  parameter int H_VISIBLE   = H_VISIBLE_AREA,
  parameter int V_VISIBLE   = V_VISIBLE_AREA,
  parameter int NUM_PADDLES = 2
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_HBlank,
  input  logic                   i_VBlank,
  input  logic                   i_Ball,
  input  logic [NUM_PADDLES-1:0] i_Paddle,
  output logic                   o_XDir,
  output logic                   o_YDir,
  output logic                   o_Hit,
  output logic                   o_MissLeft,
  output logic                   o_MissRight
`ifdef HIT_DETECTOR_COUNT_EN
  ,
  output logic [HIT_COUNT_W-1:0] o_HitCount
`endif
);

  localparam int DX_W = $clog2(H_VISIBLE);
  localparam int DY_W = $clog2(V_VISIBLE);
  localparam logic [DX_W-1:0] DX_MAX = DX_W'(H_VISIBLE - 1);
  localparam logic [DY_W-1:0] DY_MAX = DY_W'(V_VISIBLE - 1);

  logic [DX_W-1:0] dx;
  logic [DY_W-1:0] dy;
  logic            frame_end;

  raster_position #(
    .H_VISIBLE(H_VISIBLE),
    .V_VISIBLE(V_VISIBLE)
  ) u_raster (
    .i_Clk     (i_Clk),
    .i_Reset   (i_Reset),
    .i_HBlank  (i_HBlank),
    .i_VBlank  (i_VBlank),
    .dx        (dx),
    .dy        (dy),
    .o_FrameEnd(frame_end)
  );

  x_dir_e   x_dir;
  y_dir_e   y_dir;
  contact_t flags;
  contact_t seen;
  logic     pad_left_px;
  logic     pad_right_px;
  logic     ball_visible;
  logic     bounce_l;
  logic     bounce_r;
  logic     bounce_t;
  logic     bounce_b;
  logic     next_hit;
  logic     next_miss_l;
  logic     next_miss_r;

  always_comb begin
    pad_left_px  = 1'b0;
    pad_right_px = 1'b0;
    for (int i = 0; i < NUM_PADDLES; i++) begin
      if (is_left_paddle(i)) begin
        pad_left_px = pad_left_px | i_Paddle[i];
      end else begin
        pad_right_px = pad_right_px | i_Paddle[i];
      end
    end
  end

  assign ball_visible = i_Ball & ~i_HBlank & ~i_VBlank;

  always_comb begin
    seen       = '0;
    seen.hit_l = ball_visible && (dx == '0);
    seen.hit_r = ball_visible && (dx == DX_MAX);
    seen.hit_t = ball_visible && (dy == '0);
    seen.hit_b = ball_visible && (dy == DY_MAX);
    seen.pad_l = ball_visible && pad_left_px;
    seen.pad_r = ball_visible && pad_right_px;
  end

  // Only contacts on the side the ball is heading toward can cause a bounce.
  assign bounce_l    = (x_dir == DIR_LEFT)  && (flags.hit_l || flags.pad_l);
  assign bounce_r    = (x_dir == DIR_RIGHT) && (flags.hit_r || flags.pad_r);
  assign bounce_t    = (y_dir == DIR_UP)    && flags.hit_t;
  assign bounce_b    = (y_dir == DIR_DOWN)  && flags.hit_b;
  assign next_hit    = ((x_dir == DIR_LEFT) && flags.pad_l) || ((x_dir == DIR_RIGHT) && flags.pad_r);
  assign next_miss_l = (x_dir == DIR_LEFT)  && flags.hit_l && !flags.pad_l;
  assign next_miss_r = (x_dir == DIR_RIGHT) && flags.hit_r && !flags.pad_r;

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      flags       <= '0;
      x_dir       <= DIR_LEFT;
      y_dir       <= DIR_UP;
      o_Hit       <= 1'b0;
      o_MissLeft  <= 1'b0;
      o_MissRight <= 1'b0;
    end else if (frame_end) begin
      flags       <= '0;
      o_Hit       <= next_hit;
      o_MissLeft  <= next_miss_l;
      o_MissRight <= next_miss_r;
      if (bounce_l) begin
        x_dir <= DIR_RIGHT;
      end else if (bounce_r) begin
        x_dir <= DIR_LEFT;
      end
      if (bounce_t) begin
        y_dir <= DIR_DOWN;
      end else if (bounce_b) begin
        y_dir <= DIR_UP;
      end
    end else begin
      flags       <= flags | seen;
      o_Hit       <= 1'b0;
      o_MissLeft  <= 1'b0;
      o_MissRight <= 1'b0;
    end
  end

  assign o_XDir = x_dir;
  assign o_YDir = y_dir;

`ifdef HIT_DETECTOR_COUNT_EN
  // Rally counter moves on the same edge that registers the pulses; a miss clears it.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      o_HitCount <= '0;
    end else if (frame_end) begin
      if (next_miss_l || next_miss_r) begin
        o_HitCount <= '0;
      end else if (next_hit && (o_HitCount != '1)) begin
        o_HitCount <= o_HitCount + 1'b1;
      end
    end
  end
`endif

endmodule
